// File: rtl/pipereg_skid_receiver_if.sv
// Valid/ready handshake bundle between an upper stage, the skid receiver
// and the lower consumer; slave is the receiver's view.
interface pipereg_skid_receiver_if #(
   parameter int DATA_WIDTH = 256
);
   logic                  instr_valid_from_upper;
   logic                  instr_ready_to_upper;
   logic [DATA_WIDTH-1:0] upper_payload;
   logic                  instr_valid_to_lower;
   logic                  instr_ready_from_lower;
   logic [DATA_WIDTH-1:0] lower_payload;

   modport master (
      output instr_valid_from_upper,
      input  instr_ready_to_upper,
      output upper_payload,
      input  instr_valid_to_lower,
      output instr_ready_from_lower,
      input  lower_payload
   );

   modport slave (
      input  instr_valid_from_upper,
      output instr_ready_to_upper,
      input  upper_payload,
      output instr_valid_to_lower,
      input  instr_ready_from_lower,
      output lower_payload
   );
endinterface

// File: rtl/pipereg_skid_receiver.sv
// Registered-ready 2-entry skid receiver (main + skid) for the instr pipeline.
// Optional PIPEREG_SKID_PERF_EN adds a saturating upstream stall counter.
module pipereg_skid_receiver #(
   parameter int DATA_WIDTH = 256
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           flush_valid,
   pipereg_skid_receiver_if.slave         bus,
   output logic [1:0]                     occupancy
`ifdef PIPEREG_SKID_PERF_EN
   ,output logic [31:0]                   stall_cycles
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic                  in_fire;
   logic                  out_fire;

   assign in_fire  = bus.instr_valid_from_upper & ready_q;
   assign out_fire = valid_q & bus.instr_ready_from_lower;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush_valid) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_d  = bus.upper_payload;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = bus.upper_payload;
               end else if (in_fire) begin
                  skid_d  = bus.upper_payload;
                  state_d = FULL;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = BUSY;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
      // handshake flops track the next state so ready never sees lower ready
      valid_d = (state_d != EMPTY);
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   assign bus.instr_ready_to_upper = ready_q;
   assign bus.instr_valid_to_lower = valid_q;
   assign bus.lower_payload        = main_q;
   assign occupancy                = state_q;

`ifdef PIPEREG_SKID_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.instr_valid_from_upper && !ready_q &&
          (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipereg_skid_receiver.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of a 2-deep in-order buffer with registered ready.
module tb_pipereg_skid_receiver;

   localparam int DW = 256;

   logic          clock;
   logic          reset_n;
   logic          flush_valid;
   logic [1:0]    occupancy;
`ifdef PIPEREG_SKID_PERF_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   stall_exp;
`endif

   int checks;
   int errors;

   logic [DW-1:0] mq[$];

   pipereg_skid_receiver_if #(.DATA_WIDTH(DW)) bus ();

   pipereg_skid_receiver #(.DATA_WIDTH(DW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .flush_valid (flush_valid),
      .bus         (bus.slave),
      .occupancy   (occupancy)
`ifdef PIPEREG_SKID_PERF_EN
      ,.stall_cycles(stall_cycles)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_valid"}, DW'(bus.instr_valid_to_lower),
          DW'(mq.size() > 0));
      chk({tag, "_ready"}, DW'(bus.instr_ready_to_upper),
          DW'(mq.size() < 2));
      chk({tag, "_occ"}, DW'(occupancy), DW'(mq.size()));
      if (mq.size() > 0)
         chk({tag, "_data"}, bus.lower_payload, mq[0]);
`ifdef PIPEREG_SKID_PERF_EN
      chk({tag, "_stall"}, DW'(stall_cycles), DW'(stall_exp));
`endif
   endtask

   // one clock of traffic: inputs driven before the edge, checked at negedge
   task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic r, input logic f);
      bit in_f;
      bit out_f;
      bus.instr_valid_from_upper = v;
      bus.upper_payload          = d;
      bus.instr_ready_from_lower = r;
      flush_valid                = f;
      @(posedge clock);
      in_f  = v && (mq.size() < 2);
      out_f = r && (mq.size() > 0);
`ifdef PIPEREG_SKID_PERF_EN
      if (v && mq.size() == 2 && stall_exp != 32'hFFFF_FFFF)
         stall_exp = stall_exp + 32'd1;
`endif
      if (f) begin
         mq.delete();
      end else begin
         if (out_f) void'(mq.pop_front());
         if (in_f) mq.push_back(d);
      end
      @(negedge clock);
      check_outputs(tag);
      if (f) chk({tag, "_clr"}, bus.lower_payload, '0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      mq.delete();
`ifdef PIPEREG_SKID_PERF_EN
      stall_exp = '0;
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.instr_valid_from_upper = 1'b0;
      bus.upper_payload          = '0;
      bus.instr_ready_from_lower = 1'b0;
      flush_valid                = 1'b0;
      do_reset();
      repeat (2) @(negedge clock);
      check_outputs("rst");
      chk("rst_data", bus.lower_payload, '0);
      reset_n = 1'b1;
      @(negedge clock);
      check_outputs("rst_rel");

      // T2: back-to-back stream with lower ready held high
      for (int i = 0; i < 8; i++)
         cyc("t2", 1'b1, DW'(8'h10 + i), 1'b1, 1'b0);
      chk("t2_occ1", DW'(occupancy), DW'(1));
      cyc("t2_drain", 1'b0, '0, 1'b1, 1'b0);

      // T3: lower stalled, fill to FULL, C held upstream, then release
      cyc("t3", 1'b1, DW'(8'hA), 1'b0, 1'b0);
      cyc("t3", 1'b1, DW'(8'hB), 1'b0, 1'b0);
      chk("t3_full_rdy", DW'(bus.instr_ready_to_upper), DW'(0));
      cyc("t3", 1'b1, DW'(8'hC), 1'b0, 1'b0);
      cyc("t3", 1'b1, DW'(8'hC), 1'b0, 1'b0);
      cyc("t3", 1'b1, DW'(8'hC), 1'b1, 1'b0);
      chk("t3_head_b", bus.lower_payload, DW'(8'hB));
      cyc("t3", 1'b1, DW'(8'hC), 1'b1, 1'b0);
      chk("t3_head_c", bus.lower_payload, DW'(8'hC));
      cyc("t3", 1'b0, '0, 1'b1, 1'b0);
      chk("t3_empty", DW'(occupancy), DW'(0));

      // T4: flush while FULL with a concurrent upstream beat
      cyc("t4", 1'b1, DW'(8'h1), 1'b0, 1'b0);
      cyc("t4", 1'b1, DW'(8'h2), 1'b0, 1'b0);
      cyc("t4_fl", 1'b1, DW'(8'hD), 1'b1, 1'b1);
      cyc("t4", 1'b0, '0, 1'b1, 1'b0);
      chk("t4_no_d", DW'(bus.instr_valid_to_lower), DW'(0));

      // T5: BUSY with simultaneous in/out fire
      cyc("t5", 1'b1, DW'(8'h50), 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         cyc("t5", 1'b1, DW'(8'h50 + i), 1'b1, 1'b0);
         chk("t5_occ", DW'(occupancy), DW'(1));
      end
      cyc("t5", 1'b0, '0, 1'b1, 1'b0);

`ifdef PIPEREG_SKID_PERF_EN
      // T6: stall counting, flush persistence, saturation
      cyc("t6", 1'b1, DW'(8'h61), 1'b0, 1'b0);
      cyc("t6", 1'b1, DW'(8'h62), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         cyc("t6", 1'b1, DW'(8'h63), 1'b0, 1'b0);
      chk("t6_five", DW'(stall_cycles), DW'(5));
      cyc("t6_fl", 1'b0, '0, 1'b0, 1'b1);
      chk("t6_keep", DW'(stall_cycles), DW'(5));
      cyc("t6", 1'b1, DW'(8'h64), 1'b0, 1'b0);
      cyc("t6", 1'b1, DW'(8'h65), 1'b0, 1'b0);
      dut.stall_cnt_q = 32'hFFFF_FFFD;
      stall_exp       = 32'hFFFF_FFFD;
      for (int i = 0; i < 5; i++)
         cyc("t6_sat", 1'b1, DW'(8'h66), 1'b0, 1'b0);
      chk("t6_max", DW'(stall_cycles), DW'(32'hFFFF_FFFF));
      cyc("t6", 1'b0, '0, 1'b1, 1'b1);
`endif

      // random traffic
      for (int i = 0; i < 300; i++) begin
         logic [DW-1:0] d;
         d = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
         cyc("rnd", 1'($urandom_range(0, 1)), d,
             1'($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      end

      // T1: async reset while FULL, checked in the same cycle
      cyc("t1", 1'b1, DW'(8'h71), 1'b0, 1'b0);
      cyc("t1", 1'b1, DW'(8'h72), 1'b0, 1'b0);
      chk("t1_full", DW'(occupancy), DW'(2));
      #2;
      do_reset();
      chk("t1_valid0", DW'(bus.instr_valid_to_lower), DW'(0));
      chk("t1_occ0", DW'(occupancy), DW'(0));
      bus.instr_valid_from_upper = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_outputs("t1_rel");
      chk("t1_ready1", DW'(bus.instr_ready_to_upper), DW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
